// File: rtl/switch_control.sv
// NoC router switch allocator: round-robin pick of a waiting header, XY route,
// grant if the output is free, and free connections on packet release.
// Ports: clock, reset (async active-low), h, data_in (5 head flits),
//   release_i (tail pulses), ack_h (grant pulses), mux_in/mux_out (3-bit
//   per-port connection tables), in_active, out_busy. When SC_DENY_COUNTER_EN
//   is defined, deny_count (16-bit saturating deny counter) is added.
module switch_control #(
  parameter int FLIT_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4:0]          h,
  input  logic [5*FLIT_W-1:0] data_in,
  input  logic [4:0]          release_i,
  output logic [4:0]          ack_h,
  output logic [14:0]         mux_in,
  output logic [14:0]         mux_out,
  output logic [4:0]          in_active,
  output logic [4:0]          out_busy
`ifdef SC_DENY_COUNTER_EN
  ,
  output logic [15:0]         deny_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARB   = 2'd1;
  localparam logic [1:0] ROUTE = 2'd2;
  localparam logic [1:0] GRANT = 2'd3;

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam logic [ADDR_W-1:0] LX = ADDR_W'(LOCAL_X);
  localparam logic [ADDR_W-1:0] LY = ADDR_W'(LOCAL_Y);

  logic [1:0]        state_q, state_d;
  logic [2:0]        ptr_q, sel_q, dest_q;
  logic [ADDR_W-1:0] tx_q, ty_q;
  logic [4:0]        in_active_q, in_active_d;
  logic [4:0]        out_busy_q, out_busy_d;
  logic [14:0]       mux_in_q, mux_in_d;
  logic [14:0]       mux_out_q, mux_out_d;

  logic [FLIT_W-1:0] flit [5];
  logic [4:0]        req;
  logic [2:0]        win;
  logic              found;
  logic [3:0]        idx;
  logic [2:0]        dest_c;
  logic              deny;

  for (genvar g = 0; g < 5; g++) begin : g_flit
    assign flit[g] = data_in[g*FLIT_W +: FLIT_W];
  end

  // Only the coordinate field of each flit is routed on.
  logic unused_flit;
  assign unused_flit = ^data_in;

  assign req = h & ~in_active_q;

  // Round-robin scan starting just after the last winner.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx > 4'd4) idx = idx - 4'd5;
      if (!found && req[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  always_comb begin
    if (tx_q > LX)      dest_c = EAST;
    else if (tx_q < LX) dest_c = WEST;
    else if (ty_q > LY) dest_c = NORTH;
    else if (ty_q < LY) dest_c = SOUTH;
    else                dest_c = LOCAL;
  end

  // Busy check uses the registered table, so a same-cycle release
  // of the target output still denies this pass.
  assign deny = (state_q == ROUTE) && out_busy_q[dest_c];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ARB;
      ARB:     state_d = found ? ROUTE : IDLE;
      ROUTE:   state_d = deny ? IDLE : GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_active_d = in_active_q;
    out_busy_d  = out_busy_q;
    mux_in_d    = mux_in_q;
    mux_out_d   = mux_out_q;
    for (int i = 0; i < 5; i++) begin
      if (release_i[i] && in_active_q[i]) begin
        in_active_d[i] = 1'b0;
        out_busy_d[mux_in_q[i*3 +: 3]] = 1'b0;
      end
    end
    if (state_q == GRANT) begin
      in_active_d[sel_q]      = 1'b1;
      out_busy_d[dest_q]      = 1'b1;
      mux_in_d[sel_q*3 +: 3]  = dest_q;
      mux_out_d[dest_q*3 +: 3] = sel_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= LOCAL;
      sel_q       <= 3'd0;
      dest_q      <= 3'd0;
      tx_q        <= '0;
      ty_q        <= '0;
      in_active_q <= '0;
      out_busy_q  <= '0;
      mux_in_q    <= '0;
      mux_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_active_q <= in_active_d;
      out_busy_q  <= out_busy_d;
      mux_in_q    <= mux_in_d;
      mux_out_q   <= mux_out_d;
      if (state_q == ARB && found) begin
        sel_q <= win;
        ptr_q <= win;
        tx_q  <= flit[win][2*ADDR_W-1:ADDR_W];
        ty_q  <= flit[win][ADDR_W-1:0];
      end
      if (state_q == ROUTE) dest_q <= dest_c;
    end
  end

`ifdef SC_DENY_COUNTER_EN
  logic [15:0] deny_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                         deny_q <= '0;
    else if (deny && deny_q != 16'hFFFF) deny_q <= deny_q + 16'd1;
  end
  assign deny_count = deny_q;
`endif

  // Grant pulse decodes from the state register so reset cuts it at once.
  assign ack_h     = (state_q == GRANT) ? (5'b00001 << sel_q) : 5'b00000;
  assign mux_in    = mux_in_q;
  assign mux_out   = mux_out_q;
  assign in_active = in_active_q;
  assign out_busy  = out_busy_q;

endmodule
